// File: rtl/uart_pkg.sv
// Shared definitions for the UART/AXI-Stream core: widths, state encodings and
// the bit-timing helpers used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int OVERSAMPLE      = 8;
    localparam int PRESCALE_W      = 16;
    // Wide enough for a full bit period of 65535 * 8 clocks.
    localparam int COUNT_W         = PRESCALE_W + 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // A prescale of zero would make a bit zero clocks long; run it as one.
    function automatic logic [COUNT_W-1:0] prescale_eff(input logic [PRESCALE_W-1:0] prescale);
        return (prescale == '0) ? COUNT_W'(1) : COUNT_W'(prescale);
    endfunction

    // Counter reload for one full bit period (counts down to zero inclusive).
    function automatic logic [COUNT_W-1:0] bit_period_m1(input logic [PRESCALE_W-1:0] prescale);
        return prescale_eff(prescale) * COUNT_W'(OVERSAMPLE) - COUNT_W'(1);
    endfunction

    // Counter reload for half a bit period, used to reach the centre of the start bit.
    function automatic logic [COUNT_W-1:0] half_period_m1(input logic [PRESCALE_W-1:0] prescale);
        return prescale_eff(prescale) * COUNT_W'(OVERSAMPLE / 2) - COUNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_axis_rx.sv
// UART receiver: detects a start bit on the registered rxd, samples each bit at
// its centre and presents completed bytes on an AXI-Stream output register.
module uart_axis_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_rxd,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_busy,
    output logic                  o_overrun_error,
    output logic                  o_frame_error
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_state_next;
    logic                  r_rxd;
    logic [COUNT_W-1:0]    r_cnt;
    logic [COUNT_W-1:0]    w_cnt_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0] w_tdata_next;
    logic                  r_tvalid;
    logic                  w_tvalid_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_overrun;
    logic                  w_overrun_next;
    logic                  r_frame;
    logic                  w_frame_next;
    logic [COUNT_W-1:0]    w_period_m1;
    logic [COUNT_W-1:0]    w_half_m1;

    assign w_period_m1 = bit_period_m1(i_prescale);
    assign w_half_m1   = half_period_m1(i_prescale);

    assign o_tdata         = r_tdata;
    assign o_tvalid        = r_tvalid;
    assign o_busy          = r_busy;
    assign o_overrun_error = r_overrun;
    assign o_frame_error   = r_frame;

    // State register plus the single input stage on rxd (idles high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_rxd     <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rxd     <= i_rxd;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tdata   <= w_tdata_next;
            r_tvalid  <= w_tvalid_next;
            r_busy    <= w_busy_next;
            r_overrun <= w_overrun_next;
            r_frame   <= w_frame_next;
        end
    end

    // Next-state logic: mid-start check rejects glitches, then centre sampling.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_idx_next     = r_idx;
        w_shift_next   = r_shift;
        w_tdata_next   = r_tdata;
        w_tvalid_next  = r_tvalid;
        w_busy_next    = r_busy;
        w_overrun_next = 1'b0;
        w_frame_next   = 1'b0;

        // Consumer handshake; a byte completing this same cycle overrides it below.
        if (r_tvalid && i_tready) begin
            w_tvalid_next = 1'b0;
        end

        case (r_state)
            RX_IDLE: begin
                if (!r_rxd) begin
                    w_busy_next  = 1'b1;
                    w_cnt_next   = w_half_m1;
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else if (r_rxd) begin
                    // Line went back high before mid-start: not a real frame.
                    w_busy_next  = 1'b0;
                    w_state_next = RX_IDLE;
                end else begin
                    w_idx_next   = '0;
                    w_cnt_next   = w_period_m1;
                    w_state_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else begin
                    w_shift_next = {r_rxd, r_shift[DATA_WIDTH-1:1]};
                    w_cnt_next   = w_period_m1;
                    if (r_idx == LAST_IDX) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else begin
                    w_busy_next  = 1'b0;
                    w_state_next = RX_IDLE;
                    if (r_rxd) begin
                        w_tdata_next   = r_shift;
                        w_tvalid_next  = 1'b1;
                        w_overrun_next = r_tvalid && !i_tready;
                    end else begin
                        w_frame_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_axis_tx.sv
// UART transmitter: accepts one byte per AXI-Stream handshake and shifts it out
// as an 8N1 frame, LSB first. Ready is withheld for the whole frame.
module uart_axis_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic                  o_tready,
    output logic                  o_txd,
    output logic                  o_busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [COUNT_W-1:0]    r_cnt;
    logic [COUNT_W-1:0]    w_cnt_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  r_txd;
    logic                  w_txd_next;
    logic                  r_tready;
    logic                  w_tready_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic [COUNT_W-1:0]    w_period_m1;

    // Prescale is picked up afresh every time a bit period is loaded.
    assign w_period_m1 = bit_period_m1(i_prescale);

    assign o_tready = r_tready;
    assign o_txd    = r_txd;
    assign o_busy   = r_busy;

    // State register; reset returns the line to idle and aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_txd    <= 1'b1;
            r_tready <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_idx    <= w_idx_next;
            r_data   <= w_data_next;
            r_txd    <= w_txd_next;
            r_tready <= w_tready_next;
            r_busy   <= w_busy_next;
        end
    end

    // Next-state logic: every state holds for one bit period, then advances.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_idx_next    = r_idx;
        w_data_next   = r_data;
        w_txd_next    = r_txd;
        w_tready_next = r_tready;
        w_busy_next   = r_busy;

        case (r_state)
            TX_IDLE: begin
                w_tready_next = 1'b1;
                if (i_tvalid && r_tready) begin
                    w_data_next   = i_tdata;
                    w_tready_next = 1'b0;
                    w_busy_next   = 1'b1;
                    w_txd_next    = 1'b0;
                    w_cnt_next    = w_period_m1;
                    w_state_next  = TX_START;
                end
            end
            TX_START: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else begin
                    w_txd_next   = r_data[0];
                    w_data_next  = r_data >> 1;
                    w_idx_next   = '0;
                    w_cnt_next   = w_period_m1;
                    w_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else begin
                    w_cnt_next = w_period_m1;
                    if (r_idx == LAST_IDX) begin
                        w_txd_next   = 1'b1;
                        w_state_next = TX_STOP;
                    end else begin
                        w_txd_next  = r_data[0];
                        w_data_next = r_data >> 1;
                        w_idx_next  = r_idx + IDX_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - COUNT_W'(1);
                end else begin
                    w_tready_next = 1'b1;
                    w_busy_next   = 1'b0;
                    w_state_next  = TX_IDLE;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_axis_core.sv
// Full-duplex 8N1 UART with AXI-Stream byte ports. Pure wiring: the transmitter
// and receiver run independently and share only clock, reset and prescale.
module uart_axis_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [PRESCALE_W-1:0] prescale
);

    uart_axis_tx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_prescale (prescale),
        .i_tdata    (input_axis_tdata),
        .i_tvalid   (input_axis_tvalid),
        .o_tready   (input_axis_tready),
        .o_txd      (txd),
        .o_busy     (tx_busy)
    );

    uart_axis_rx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_prescale      (prescale),
        .i_rxd           (rxd),
        .o_tdata         (output_axis_tdata),
        .o_tvalid        (output_axis_tvalid),
        .i_tready        (output_axis_tready),
        .o_busy          (rx_busy),
        .o_overrun_error (rx_overrun_error),
        .o_frame_error   (rx_frame_error)
    );

endmodule

// File: tb/tb_uart_axis_core.sv
// Directed bench for uart_axis_core: reset, loopback, back-to-back frames,
// overrun, framing error, glitch rejection and reset during a frame.
module tb_uart_axis_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_tdata = 8'h00;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b0;
    logic        rxd;
    logic        txd;
    logic        tx_busy;
    logic        rx_busy;
    logic        rx_ovr;
    logic        rx_fe;
    logic [15:0] prescale = 16'd2;

    logic        loopback = 1'b1;
    logic        rxd_drv = 1'b1;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ovr_cnt = 0;
    int          fe_cnt = 0;
    logic [7:0]  rx_q[$];

    assign rxd = loopback ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_axis_core dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_tdata),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .output_axis_tdata  (out_tdata),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .rxd                (rxd),
        .txd                (txd),
        .tx_busy            (tx_busy),
        .rx_busy            (rx_busy),
        .rx_overrun_error   (rx_ovr),
        .rx_frame_error     (rx_fe),
        .prescale           (prescale)
    );

    // Record accepted RX bytes and count error-pulse cycles as the DUT sees them.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && out_tvalid && out_tready) rx_q.push_back(out_tdata);
        if (rx_ovr) ovr_cnt = ovr_cnt + 1;
        if (rx_fe) fe_cnt = fe_cnt + 1;
    end

    // Offer a byte and wait for the handshake; returns on the negedge one clock after it.
    task automatic tx_send(input logic [7:0] b, output bit ok);
        @(negedge clk);
        in_tdata  = b;
        in_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (in_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_tvalid = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        rxd_drv = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_rx(input int count, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rx_q.size() >= count) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (in_tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b expected 0", in_tready); end
        checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_rx_tvalid: got %b expected 0", out_tvalid); end
        checks++; if (out_tdata !== 8'h00) begin failures++; $display("FAIL reset_rx_tdata: got %h expected 00", out_tdata); end
        checks++; if ({tx_busy, rx_busy} !== 2'b00) begin failures++; $display("FAIL reset_busy: got %b expected 00", {tx_busy, rx_busy}); end
        checks++; if ({rx_ovr, rx_fe} !== 2'b00) begin failures++; $display("FAIL reset_errors: got %b expected 00", {rx_ovr, rx_fe}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_tready !== 1'b1) begin failures++; $display("FAIL release_tready: got %b expected 1", in_tready); end
    endtask

    task automatic test_loopback;
        bit         ok;
        int         n;
        logic [9:0] pat;
        logic       busy_mid;
        int         ovr0;
        int         fe0;
        loopback   = 1'b1;
        out_tready = 1'b0;
        rx_q.delete();
        ovr0 = ovr_cnt;
        fe0  = fe_cnt;
        tx_send(8'h55, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_handshake: got timeout expected tready"); end
        n = 1;
        busy_mid = 1'b0;
        // Sample each bit at its centre: bit b spans clocks 16b+1 .. 16b+16 after the handshake.
        for (int b = 0; b < 10; b++) begin
            while (n < 8 + 16 * b) begin
                @(negedge clk);
                n++;
            end
            pat[b] = txd;
            if (b == 0) busy_mid = tx_busy;
        end
        checks++; if (pat !== 10'b1010101010) begin failures++; $display("FAIL loop_txd_pattern: got %b expected 1010101010", pat); end
        checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL loop_tx_busy: got %b expected 1", busy_mid); end
        while (!out_tvalid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n < 150 || n > 165) begin failures++; $display("FAIL loop_latency: got %0d expected 150..165", n); end
        checks++; if (out_tdata !== 8'h55) begin failures++; $display("FAIL loop_tdata: got %h expected 55", out_tdata); end
        checks++; if (ovr_cnt != ovr0 || fe_cnt != fe0) begin failures++; $display("FAIL loop_errors: got ovr=%0d fe=%0d expected 0 0", ovr_cnt - ovr0, fe_cnt - fe0); end
        out_tready = 1'b1;
        @(negedge clk);
        checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL loop_tvalid_clear: got %b expected 0", out_tvalid); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int h1;
        int h2;
        h1 = 0;
        h2 = 0;
        loopback   = 1'b1;
        out_tready = 1'b1;
        rx_q.delete();
        @(negedge clk);
        in_tdata  = 8'h55;
        in_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (in_tready) begin ok = 1'b1; h1 = cyc; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL b2b_first_handshake: got timeout expected tready"); end
        @(negedge clk);
        in_tdata = 8'hAA;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (in_tready) begin ok = 1'b1; h2 = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_tvalid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL b2b_second_handshake: got timeout expected tready"); end
        // A frame is 160 clocks; the next start may follow with at most one clock of extra idle.
        checks++; if (h2 - h1 < 160 || h2 - h1 > 161) begin failures++; $display("FAIL b2b_gap: got %0d expected 160..161", h2 - h1); end
        checks++; if (txd !== 1'b0) begin failures++; $display("FAIL b2b_second_start: got %b expected 0", txd); end
        wait_rx(2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h55) begin failures++; $display("FAIL b2b_rx_byte0: got %h expected 55", rx_q[0]); end
            checks++; if (rx_q[1] !== 8'hAA) begin failures++; $display("FAIL b2b_rx_byte1: got %h expected aa", rx_q[1]); end
        end
    endtask

    task automatic test_overrun;
        bit ok;
        int ovr0;
        int fe0;
        loopback   = 1'b1;
        out_tready = 1'b0;
        rx_q.delete();
        ovr0 = ovr_cnt;
        fe0  = fe_cnt;
        tx_send(8'h12, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_send1: got timeout expected tready"); end
        tx_send(8'h34, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_send2: got timeout expected tready"); end
        for (int i = 0; i < 400; i++) begin
            if (ovr_cnt != ovr0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (ovr_cnt - ovr0 != 1) begin failures++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - ovr0); end
        checks++; if (out_tdata !== 8'h34 || out_tvalid !== 1'b1) begin failures++; $display("FAIL ovr_tdata: got %h/%b expected 34/1", out_tdata, out_tvalid); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL ovr_frame_err: got %0d expected 0", fe_cnt - fe0); end
        out_tready = 1'b1;
        @(negedge clk);
        checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL ovr_tvalid_clear: got %b expected 0", out_tvalid); end
        checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL ovr_accepted: got %0d expected 1", rx_q.size()); end
    endtask

    task automatic test_framing_glitch;
        logic [7:0] b;
        int         ovr0;
        int         fe0;
        bit         saw_busy;
        b = 8'hA5;
        out_tready = 1'b0;
        rx_q.delete();
        rxd_drv  = 1'b1;
        loopback = 1'b0;
        repeat (5) @(negedge clk);
        ovr0 = ovr_cnt;
        fe0  = fe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b0);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cnt - fe0); end
        checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL frame_tvalid: got %b expected 0", out_tvalid); end
        checks++; if (ovr_cnt != ovr0) begin failures++; $display("FAIL frame_overrun: got %0d expected 0", ovr_cnt - ovr0); end
        fe0 = fe_cnt;
        saw_busy = 1'b0;
        rxd_drv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) rxd_drv = 1'b1;
            if (rx_busy) saw_busy = 1'b1;
        end
        checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); end
        checks++; if (fe_cnt != fe0 || out_tvalid !== 1'b0) begin failures++; $display("FAIL glitch_no_byte: got fe=%0d tvalid=%b expected 0 0", fe_cnt - fe0, out_tvalid); end
        loopback = 1'b1;
    endtask

    task automatic test_reset_midframe;
        bit ok;
        loopback   = 1'b1;
        out_tready = 1'b1;
        rx_q.delete();
        tx_send(8'h5A, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_send: got timeout expected tready"); end
        // Clock 70 after the handshake lies inside data bit 3 (clocks 65..80).
        repeat (69) @(negedge clk);
        checks++; if (tx_busy !== 1'b1 || rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b%b expected 11", tx_busy, rx_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_txd: got %b expected 1", txd); end
        checks++; if ({tx_busy, rx_busy, in_tready} !== 3'b000) begin failures++; $display("FAIL mid_state: got %b expected 000", {tx_busy, rx_busy, in_tready}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (rx_q.size() != 0 || out_tvalid !== 1'b0) begin failures++; $display("FAIL mid_no_partial: got %0d bytes expected 0", rx_q.size()); end
        tx_send(8'h5A, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_resend: got timeout expected tready"); end
        wait_rx(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_rx_count: got %0d expected 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'h5A) begin failures++; $display("FAIL mid_rx_byte: got %h expected 5a", rx_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_framing_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
